alu_operand_sequencer: RTL and testbench

//   Upstream front-end for the simple ALU. An operator keys in two 4-bit operands and a 3-bit opcode

---
 rtl/alu_operand_sequencer.sv | 129 ++++++++++++
 tb/tb_alu_operand_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// Operand sequencer for the simple ALU. It takes two operands and an opcode from one
// strobe button, drives the registered ALU bus, and captures the ALU result one cycle
// later. It also keeps a wrapping count of completed operations.
module alu_operand_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_strobe,
    input  logic               i_clear,
    input  logic [3:0]         i_nibble,
    input  logic [2:0]         i_opcode,
    input  logic [7:0]         i_alu_result,
    output logic [7:0]         o_instruction,
    output logic [7:0]         o_data,
    output logic [7:0]         o_result,
    output logic               o_valid,
    output logic [1:0]         o_state,
    output logic [COUNT_W-1:0] o_op_count
);

    // state  | meaning
    // LOAD_A | waiting for the first operand (high nibble of o_data)
    // LOAD_B | waiting for the second operand and the opcode
    // EXEC   | single cycle; ALU bus is stable, result captured at the end
    // SHOW   | result held and valid; the next strobe starts a new operation
    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        SHOW   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] stb_sync;
    logic [SYNC_STAGES-1:0] clr_sync;
    logic                   stb_prev;
    logic                   stb_p;
    logic                   clr_l;

    logic load_a;
    logic load_b;
    logic capture;
    logic drop_valid;

    // Synchronizer chains for the raw buttons, plus history for strobe edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stb_sync <= '0;
            clr_sync <= '0;
            stb_prev <= 1'b0;
        end else begin
            stb_sync <= {stb_sync[SYNC_STAGES-2:0], i_strobe};
            clr_sync <= {clr_sync[SYNC_STAGES-2:0], i_clear};
            stb_prev <= stb_sync[SYNC_STAGES-1];
        end
    end

    assign stb_p = stb_sync[SYNC_STAGES-1] & ~stb_prev;
    assign clr_l = clr_sync[SYNC_STAGES-1];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= LOAD_A;
        else        state <= state_nxt;
    end

    // Next-state and datapath enables; clear overrides every strobe action, including EXEC capture
    always_comb begin
        state_nxt  = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        capture    = 1'b0;
        drop_valid = 1'b0;
        if (clr_l) begin
            state_nxt  = LOAD_A;
            drop_valid = 1'b1;
        end else begin
            case (state)
                LOAD_A: if (stb_p) begin
                    load_a     = 1'b1;
                    drop_valid = 1'b1;
                    state_nxt  = LOAD_B;
                end
                LOAD_B: if (stb_p) begin
                    load_b    = 1'b1;
                    state_nxt = EXEC;
                end
                EXEC: begin
                    capture   = 1'b1;
                    state_nxt = SHOW;
                end
                SHOW: if (stb_p) begin
                    drop_valid = 1'b1;
                    state_nxt  = LOAD_A;
                end
                default: state_nxt = LOAD_A;
            endcase
        end
    end

    // Registered ALU bus, held result and operation counter; they change only on their enables
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_instruction <= '0;
            o_data        <= '0;
            o_result      <= '0;
            o_valid       <= 1'b0;
            o_op_count    <= '0;
        end else begin
            if (load_a) o_data[7:4] <= i_nibble;
            if (load_b) begin
                o_data[3:0]   <= i_nibble;
                o_instruction <= {5'b0, i_opcode};
            end
            if (capture) begin
                o_result   <= i_alu_result;
                o_valid    <= 1'b1;
                o_op_count <= o_op_count + 1'b1;
            end
            if (drop_valid) o_valid <= 1'b0;
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a small behavioural ALU model.
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_strobe;
    logic       i_clear;
    logic [3:0] i_nibble;
    logic [2:0] i_opcode;
    logic [7:0] i_alu_result;
    logic [7:0] o_instruction;
    logic [7:0] o_data;
    logic [7:0] o_result;
    logic       o_valid;
    logic [1:0] o_state;
    logic [3:0] o_op_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt;

    alu_operand_sequencer #(.SYNC_STAGES(2), .COUNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_strobe      (i_strobe),
        .i_clear       (i_clear),
        .i_nibble      (i_nibble),
        .i_opcode      (i_opcode),
        .i_alu_result  (i_alu_result),
        .o_instruction (o_instruction),
        .o_data        (o_data),
        .o_result      (o_result),
        .o_valid       (o_valid),
        .o_state       (o_state),
        .o_op_count    (o_op_count)
    );

    always #5 clk = ~clk;

    // ALU model: 100 adds the operands, 101 subtracts A from B, anything else inverts the data bus
    always_comb begin
        case (o_instruction[2:0])
            3'b100:  i_alu_result = {4'b0, o_data[7:4]} + {4'b0, o_data[3:0]};
            3'b101:  i_alu_result = {4'b0, o_data[3:0]} - {4'b0, o_data[7:4]};
            default: i_alu_result = ~o_data;
        endcase
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete button press: hold long enough to pass the synchronizer and act, then release and settle
    task automatic press(input logic [3:0] nib, input logic [2:0] op);
        @(negedge clk);
        i_nibble = nib;
        i_opcode = op;
        i_strobe = 1'b1;
        repeat (6) @(negedge clk);
        i_strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b1;
        i_strobe = 1'b0;
        i_clear  = 1'b0;
        i_nibble = 4'h0;
        i_opcode = 3'b000;

        // 1: reset with the strobe toggling
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_strobe = ~i_strobe;
            @(negedge clk);
        end
        check("rst_state", {6'b0, o_state}, 8'h00);
        check("rst_instr", o_instruction, 8'h00);
        check("rst_data", o_data, 8'h00);
        check("rst_result", o_result, 8'h00);
        check("rst_valid", {7'b0, o_valid}, 8'h00);
        check("rst_count", {4'b0, o_op_count}, 8'h00);
        i_strobe = 1'b0;
        rst_n    = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_idle_state", {6'b0, o_state}, 8'h00);

        // 2: add 9 + 3
        press(4'h9, 3'b000);
        check("add_a_state", {6'b0, o_state}, 8'h01);
        check("add_a_data", o_data, 8'h90);
        press(4'h3, 3'b100);
        check("add_state", {6'b0, o_state}, 8'h03);
        check("add_data", o_data, 8'h93);
        check("add_instr", o_instruction, 8'h04);
        check("add_result", o_result, 8'h0C);
        check("add_valid", {7'b0, o_valid}, 8'h01);
        check("add_count", {4'b0, o_op_count}, 8'h01);
        press(4'hE, 3'b111);
        check("add_show_state", {6'b0, o_state}, 8'h00);
        check("add_show_valid", {7'b0, o_valid}, 8'h00);
        check("add_show_data", o_data, 8'h93);
        check("add_show_result", o_result, 8'h0C);

        // 3: strobe held for 20 cycles gives exactly one capture
        @(negedge clk);
        i_nibble = 4'h5;
        i_strobe = 1'b1;
        repeat (20) @(negedge clk);
        check("held_state", {6'b0, o_state}, 8'h01);
        check("held_data", o_data, 8'h53);
        i_strobe = 1'b0;
        repeat (4) @(negedge clk);
        check("held_release_state", {6'b0, o_state}, 8'h01);

        // 4: clear and strobe edge together in LOAD_B
        @(negedge clk);
        i_nibble = 4'hA;
        i_clear  = 1'b1;
        i_strobe = 1'b1;
        repeat (6) @(negedge clk);
        check("clr_state", {6'b0, o_state}, 8'h00);
        check("clr_data", o_data, 8'h53);
        check("clr_valid", {7'b0, o_valid}, 8'h00);
        check("clr_count", {4'b0, o_op_count}, 8'h01);
        i_clear  = 1'b0;
        i_strobe = 1'b0;
        repeat (4) @(negedge clk);
        check("clr_release_state", {6'b0, o_state}, 8'h00);

        // 5: counter wrap, 16 operations in total since reset then one more
        exp_cnt = 1;
        for (int n = 0; n < 16; n++) begin
            press(4'(n), 3'b100);
            press(4'(15 - n), 3'b100);
            exp_cnt = (exp_cnt + 1) % 16;
            check("wrap_result", o_result, 8'h0F);
            check("wrap_count", {4'b0, o_op_count}, 8'(exp_cnt));
            press(4'h0, 3'b000);
        end
        check("wrap_final_count", {4'b0, o_op_count}, 8'h01);

        // 6: subtract, then strobe in SHOW
        press(4'h2, 3'b000);
        press(4'h7, 3'b101);
        check("sub_result", o_result, 8'h05);
        check("sub_instr", o_instruction, 8'h05);
        check("sub_state", {6'b0, o_state}, 8'h03);
        press(4'hF, 3'b000);
        check("sub_show_valid", {7'b0, o_valid}, 8'h00);
        check("sub_show_state", {6'b0, o_state}, 8'h00);
        check("sub_show_result", o_result, 8'h05);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
